// File: rtl/vga_sync_monitor.sv
// VGA receive-side timing monitor: recovers x/y from observed syncs,
// checks line/frame timing, declares lock and checksums locked frames.
module vga_sync_monitor #(
  parameter int   H_TOTAL      = 800,
  parameter int   H_ACTIVE     = 640,
  parameter int   H_SYNC_START = 656,
  parameter int   H_SYNC_LEN   = 96,
  parameter int   V_TOTAL      = 449,
  parameter int   V_ACTIVE     = 400,
  parameter int   V_SYNC_START = 412,
  parameter logic HS_POL       = 1'b0,
  parameter logic VS_POL       = 1'b1,
  parameter int   LOCK_FRAMES  = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [8:0]  rgb_in,
  output logic [9:0]  x_rx,
  output logic [9:0]  y_rx,
  output logic        de,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  err_count,
  output logic [23:0] frame_sum,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_ALIGN,
    S_LOCKED
  } state_t;

  localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_SYNC = 10'(H_SYNC_START);
  localparam logic [9:0]  Y_SYNC = 10'(V_SYNC_START);
  localparam logic [11:0] H_LEN  = 12'(H_TOTAL);
  localparam logic [11:0] H_TMO  = 12'(2 * H_TOTAL);
  localparam logic [9:0]  H_WID  = 10'(H_SYNC_LEN);
  localparam logic [9:0]  V_LEN  = 10'(V_TOTAL);
  localparam logic [7:0]  N_LOCK = 8'(LOCK_FRAMES);

  state_t      state;
  state_t      state_d;
  logic [7:0]  clean;
  logic [7:0]  clean_d;

  logic        hs_s;
  logic        vs_s;
  logic [8:0]  rgb_q;
  logic        hs_seen;
  logic        vs_seen;
  logic [11:0] hlen;
  logic [9:0]  hwid;
  logic [9:0]  vlen;
  logic        frame_err;
  logic [23:0] acc;

  logic        hs_now;
  logic        vs_now;
  logic        hs_lead;
  logic        hs_trail;
  logic        vs_lead;
  logic        x_wrap;
  logic        timeout;
  logic        h_err_c;
  logic        v_err_c;
  logic        any_err;
  logic [9:0]  v_cnt;
  logic [23:0] add;

  assign hs_now   = (hsync == HS_POL);
  assign vs_now   = (vsync == VS_POL);
  assign hs_lead  = p_tick & hs_now & ~hs_s;
  assign hs_trail = p_tick & ~hs_now & hs_s;
  assign vs_lead  = p_tick & vs_now & ~vs_s;
  assign x_wrap   = p_tick & ~hs_lead
                  & (x_rx == X_LAST);

  // Watchdog runs only once an edge has been
  // seen, so a dead input reports once.
  assign timeout  = p_tick & hs_seen
                  & ~hs_lead & (hlen >= H_TMO);

  assign h_err_c  = (hs_lead & hs_seen
                     & (hlen != H_LEN))
                  | (hs_trail & hs_seen
                     & (hwid != H_WID))
                  | timeout;

  // The wrap on the edge tick belongs to
  // the frame that is closing.
  assign v_cnt    = vlen + {9'd0, x_wrap};
  assign v_err_c  = vs_lead & vs_seen
                  & (v_cnt != V_LEN);
  assign any_err  = h_err_c | v_err_c;

  assign locked   = (state == S_LOCKED);
  assign de       = locked
                  & (x_rx < 10'(H_ACTIVE))
                  & (y_rx < 10'(V_ACTIVE));
  assign add      = de ? {15'd0, rgb_q} : 24'd0;

  always_comb begin
    state_d = state;
    clean_d = clean;
    if (timeout) begin
      state_d = S_SEARCH;
      clean_d = 8'd0;
    end else begin
      unique case (state)
        S_SEARCH: begin
          if (vs_lead) begin
            state_d = S_ALIGN;
            clean_d = 8'd0;
          end
        end
        S_ALIGN: begin
          if (any_err) begin
            clean_d = 8'd0;
          end else if (vs_lead) begin
            if (frame_err) begin
              clean_d = 8'd0;
            end else if (clean + 8'd1
                         >= N_LOCK) begin
              state_d = S_LOCKED;
              clean_d = 8'd0;
            end else begin
              clean_d = clean + 8'd1;
            end
          end
        end
        S_LOCKED: begin
          if (any_err) begin
            state_d = S_SEARCH;
            clean_d = 8'd0;
          end
        end
        default: begin
          state_d = S_SEARCH;
          clean_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100MHz
              or negedge reset) begin
    if (!reset) begin
      state <= S_SEARCH;
      clean <= 8'd0;
    end else begin
      state <= state_d;
      clean <= clean_d;
    end
  end

  always_ff @(posedge clk_100MHz
              or negedge reset) begin
    if (!reset) begin
      hs_s      <= 1'b0;
      vs_s      <= 1'b0;
      rgb_q     <= 9'd0;
      hs_seen   <= 1'b0;
      vs_seen   <= 1'b0;
      hlen      <= 12'd0;
      hwid      <= 10'd0;
      vlen      <= 10'd0;
      frame_err <= 1'b0;
      x_rx      <= 10'd0;
      y_rx      <= 10'd0;
    end else if (p_tick) begin
      hs_s  <= hs_now;
      vs_s  <= vs_now;
      rgb_q <= rgb_in;

      if (hs_lead)
        x_rx <= X_SYNC;
      else if (x_rx == X_LAST)
        x_rx <= 10'd0;
      else
        x_rx <= x_rx + 10'd1;

      if (vs_lead)
        y_rx <= Y_SYNC;
      else if (x_wrap)
        y_rx <= (y_rx == Y_LAST)
              ? 10'd0 : y_rx + 10'd1;

      if (hs_lead)
        hlen <= 12'd1;
      else if (timeout)
        hlen <= 12'd0;
      else if (hlen != '1)
        hlen <= hlen + 12'd1;

      if (hs_lead)
        hwid <= 10'd1;
      else if (hs_now && hwid != '1)
        hwid <= hwid + 10'd1;

      if (timeout)
        hs_seen <= 1'b0;
      else if (hs_lead)
        hs_seen <= 1'b1;

      if (timeout)
        vs_seen <= 1'b0;
      else if (vs_lead)
        vs_seen <= 1'b1;

      if (vs_lead)
        vlen <= 10'd0;
      else if (x_wrap && vlen != '1)
        vlen <= vlen + 10'd1;

      if (vs_lead)
        frame_err <= 1'b0;
      else if (any_err)
        frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz
              or negedge reset) begin
    if (!reset) begin
      h_err     <= 1'b0;
      v_err     <= 1'b0;
      err_count <= 8'd0;
    end else begin
      h_err <= h_err_c;
      v_err <= v_err_c;
      if (locked && any_err
          && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Accumulation only runs while staying
  // locked, so the lock edge discards the
  // partial frame and a drop clears it.
  always_ff @(posedge clk_100MHz
              or negedge reset) begin
    if (!reset) begin
      acc        <= 24'd0;
      frame_sum  <= 24'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (p_tick) begin
        if (!locked
            || state_d != S_LOCKED) begin
          acc <= 24'd0;
        end else if (vs_lead) begin
          frame_sum  <= acc + add;
          frame_done <= 1'b1;
          acc        <= 24'd0;
        end else begin
          acc <= acc + add;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: scaled-down VGA generator, checksum
// scoreboard and per-scenario tasks.
module tb_vga_sync_monitor;

  localparam int HT  = 40;
  localparam int HA  = 32;
  localparam int HSS = 34;
  localparam int HSL = 4;
  localparam int VT  = 12;
  localparam int VA  = 8;
  localparam int VSS = 9;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_tick = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b0;
  logic [8:0]  rgb_in = 9'd0;
  logic [9:0]  x_rx;
  logic [9:0]  y_rx;
  logic        de;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic [7:0]  err_count;
  logic [23:0] frame_sum;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;
  int n_herr = 0;
  int n_verr = 0;
  int n_done = 0;
  int n_de   = 0;

  logic [23:0] sum_q[$];
  logic [23:0] exp_sum;
  logic [23:0] run_sum = 24'd0;
  logic [23:0] last_sum = 24'd0;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA),
    .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_ACTIVE(VA),
    .V_SYNC_START(VSS),
    .HS_POL(HSP), .VS_POL(VSP),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_100MHz(clk),
    .reset(rst_n),
    .p_tick(p_tick),
    .hsync(hsync),
    .vsync(vsync),
    .rgb_in(rgb_in),
    .x_rx(x_rx),
    .y_rx(y_rx),
    .de(de),
    .locked(locked),
    .h_err(h_err),
    .v_err(v_err),
    .err_count(err_count),
    .frame_sum(frame_sum),
    .frame_done(frame_done)
  );

  // Checksum scoreboard: pops the expected sum on each frame_done.
  always @(negedge clk) begin
    if (h_err) n_herr++;
    if (v_err) n_verr++;
    if (frame_done) begin
      n_done++;
      checks++;
      if (sum_q.size() == 0) begin
        fails++;
        $display("FAIL frame_sum_unexpected: got %0d, required no update",
                 frame_sum);
      end else begin
        exp_sum = sum_q.pop_front();
        if (frame_sum !== exp_sum) begin
          fails++;
          $display("FAIL frame_sum: got %0d, required %0d",
                   frame_sum, exp_sum);
        end
      end
    end
  end

  task automatic px(input logic h, input logic v,
                    input logic [8:0] rgb, input bit chk,
                    input int ex, input int ey);
    hsync  = h;
    vsync  = v;
    rgb_in = rgb;
    p_tick = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    if (de) n_de++;
    if (chk) begin
      checks++;
      if (x_rx !== 10'(ex) || y_rx !== 10'(ey)) begin
        fails++;
        $display("FAIL xy: got %0d,%0d required %0d,%0d",
                 x_rx, y_rx, ex, ey);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int y0, input int lines,
                           input int short_y, input int narrow_y,
                           input int hold_y, input bit const_rgb,
                           input bit exp_done, input bit chk);
    int len;
    int w;
    logic ha;
    logic va;
    logic [8:0] r;
    if (y0 == 0) run_sum = 24'd0;
    for (int y = y0; y < lines; y++) begin
      len = (y == short_y) ? HT - 1 : HT;
      w   = (y == narrow_y) ? HSL - 1 : HSL;
      for (int x = 0; x < len; x++) begin
        ha = (x >= HSS) && (x < HSS + w)
           && !(hold_y >= 0 && y >= hold_y && y < hold_y + 3);
        va = (y >= VSS) && (y < VSS + 2);
        r  = const_rgb ? 9'h1FF : 9'(x * 3 + y * 7);
        if (x < HA && y < VA) run_sum = run_sum + {15'd0, r};
        if (exp_done && y == VSS && x == 0) begin
          sum_q.push_back(run_sum);
          last_sum = run_sum;
        end
        px(ha ? HSP : ~HSP, va ? VSP : ~VSP, r, chk, x, y);
      end
    end
  endtask

  task automatic chk_lock(input logic exp, input string tag);
    checks++;
    if (locked !== exp) begin
      fails++;
      $display("FAIL %s: locked=%0b required %0b", tag, locked, exp);
    end
  endtask

  task automatic chk_int(input int got, input int exp, input string tag);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic relock();
    run_frame(0, VT, -1, -1, -1, 0, 0, 1);
    chk_lock(1'b0, "relock_clean1");
    run_frame(0, VT, -1, -1, -1, 0, 0, 1);
    chk_lock(1'b1, "relock_clean2");
  endtask

  task automatic test_reset();
    checks++;
    if ({x_rx, y_rx, de, locked, h_err, v_err,
         err_count, frame_sum, frame_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: x=%0d y=%0d lk=%0b ec=%0d fs=%0d",
               x_rx, y_rx, locked, err_count, frame_sum);
    end
  endtask

  task automatic test_lock();
    int h0;
    int v0;
    h0 = n_herr;
    v0 = n_verr;
    run_frame(0, VT, -1, -1, -1, 0, 0, 0);
    chk_lock(1'b0, "lock_edge1");
    run_frame(0, VT, -1, -1, -1, 0, 0, 1);
    chk_lock(1'b0, "lock_edge2");
    run_frame(0, VT, -1, -1, -1, 0, 0, 1);
    chk_lock(1'b1, "lock_edge3");
    n_de = 0;
    run_frame(0, VT, -1, -1, -1, 0, 1, 1);
    chk_int(n_de, HA * VA, "de_count");
    chk_int(n_herr, h0, "clean_h_err");
    chk_int(n_verr, v0, "clean_v_err");
  endtask

  task automatic test_checksum();
    int d0;
    d0 = n_done;
    run_frame(0, VT, -1, -1, -1, 1, 1, 1);
    run_frame(0, VT, -1, -1, -1, 1, 1, 1);
    chk_int(n_done, d0 + 2, "done_per_frame");
    chk_int(int'(err_count), 0, "err_count_clean");
  endtask

  task automatic test_short_line();
    int h0;
    h0 = n_herr;
    run_frame(0, VT, 3, -1, -1, 0, 0, 0);
    chk_int(n_herr, h0 + 1, "short_line_h_err");
    chk_lock(1'b0, "short_line_unlock");
    chk_int(int'(err_count), 1, "short_line_err_count");
    relock();
    run_frame(0, VT, -1, -1, -1, 0, 1, 1);
  endtask

  task automatic test_narrow_sync();
    int h0;
    h0 = n_herr;
    run_frame(0, VT, -1, 3, -1, 0, 0, 0);
    chk_int(n_herr, h0 + 1, "narrow_h_err");
    chk_lock(1'b0, "narrow_unlock");
    chk_int(int'(err_count), 2, "narrow_err_count");
    relock();
  endtask

  task automatic test_short_frame();
    int v0;
    int h0;
    run_frame(0, VT - 1, -1, -1, -1, 0, 1, 1);
    v0 = n_verr;
    h0 = n_herr;
    run_frame(0, VT, -1, -1, -1, 0, 0, 0);
    chk_int(n_verr, v0 + 1, "short_frame_v_err");
    chk_int(n_herr, h0, "short_frame_no_h_err");
    chk_int(int'(err_count), 3, "short_frame_err_count");
    chk_lock(1'b0, "short_frame_unlock");
    checks++;
    if (frame_sum !== last_sum) begin
      fails++;
      $display("FAIL frame_sum_hold: got %0d required %0d",
               frame_sum, last_sum);
    end
    run_frame(0, VT, -1, -1, -1, 0, 0, 0);
    relock();
  endtask

  task automatic test_ptick_idle();
    int h0;
    h0 = n_herr;
    run_frame(0, 3, -1, -1, -1, 0, 0, 1);
    repeat (400) @(posedge clk);
    #1;
    chk_int(int'(x_rx), HT - 1, "idle_x_hold");
    chk_int(int'(y_rx), 2, "idle_y_hold");
    chk_lock(1'b1, "idle_lock_hold");
    chk_int(n_herr, h0, "idle_no_timeout");
    run_frame(3, VT, -1, -1, -1, 0, 1, 1);
  endtask

  task automatic test_timeout();
    int h0;
    int v0;
    h0 = n_herr;
    v0 = n_verr;
    run_frame(0, VT, -1, -1, 2, 0, 0, 0);
    chk_int(n_herr, h0 + 1, "timeout_h_err");
    chk_int(n_verr, v0, "timeout_no_v_err");
    chk_lock(1'b0, "timeout_unlock");
    chk_int(int'(err_count), 4, "timeout_err_count");
    relock();
  endtask

  task automatic test_async_reset();
    chk_int(sum_q.size(), 0, "scoreboard_drained");
    run_frame(0, 5, -1, -1, -1, 0, 0, 1);
    chk_int(int'(err_count), 4, "pre_reset_err_count");
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_lock();
    test_checksum();
    test_short_line();
    test_narrow_sync();
    test_short_frame();
    test_ptick_idle();
    test_timeout();
    test_async_reset();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
